// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: widths, reset and
// write-enable levels, the neutral register address and the stall bit positions.
package ex_mem_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int STALL_W = 6;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [DATA_W-1:0]   ZeroWord   = '0;
  localparam logic [2*DATA_W-1:0] ZeroDWord  = '0;
  localparam logic [REG_AW-1:0]   NOPRegAddr = '0;
  localparam logic [1:0]          ZeroCnt    = 2'b00;

  // Stall vector positions this stage looks at.
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

endpackage

// File: rtl/ex_mem_if.sv
// Bundle of the signals crossing the EX/MEM boundary. The master side is the
// EX stage plus stall controller; the slave side is the pipeline register.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic [STALL_W-1:0]  stall;
  logic                flush;

  logic [REG_AW-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic                ex_whilo;
  logic [2*DATA_W-1:0] hilo_temp_i;
  logic [1:0]          cnt_i;

  logic [REG_AW-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_whilo;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [1:0]          cnt_o;

  modport master (
    output stall, flush,
    output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o
  );

  modport slave (
    input  stall, flush,
    input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o
  );

endinterface

// File: rtl/ex_mem.sv
// EX->MEM pipeline register. Each edge it either clears (flush), inserts a
// bubble while keeping MADD/MSUB progress, loads the EX results, or holds.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_mem_if.slave bus
);

  logic [REG_AW-1:0]   mem_wd_q;
  logic                mem_wreg_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   mem_hi_q;
  logic [DATA_W-1:0]   mem_lo_q;
  logic                mem_whilo_q;
  logic [2*DATA_W-1:0] hilo_temp_q;
  logic [1:0]          cnt_q;

  // Only the EX and MEM stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{bus.stall[STALL_W-1:STALL_MEM+1], bus.stall[STALL_EX-1:0]};

  // Priority flush > bubble > load > hold; MEM+EX both stalled falls through to hold.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      mem_wd_q    <= NOPRegAddr;
      mem_wreg_q  <= WriteDisable;
      mem_wdata_q <= ZeroWord;
      mem_hi_q    <= ZeroWord;
      mem_lo_q    <= ZeroWord;
      mem_whilo_q <= WriteDisable;
      hilo_temp_q <= ZeroDWord;
      cnt_q       <= ZeroCnt;
    end else if (bus.flush) begin
      mem_wd_q    <= NOPRegAddr;
      mem_wreg_q  <= WriteDisable;
      mem_wdata_q <= ZeroWord;
      mem_hi_q    <= ZeroWord;
      mem_lo_q    <= ZeroWord;
      mem_whilo_q <= WriteDisable;
      hilo_temp_q <= ZeroDWord;
      cnt_q       <= ZeroCnt;
    end else if (bus.stall[STALL_EX] && !bus.stall[STALL_MEM]) begin
      // MEM keeps running while EX is stuck: send it a no-op, but remember
      // where the multi-cycle multiply-accumulate got to.
      mem_wd_q    <= NOPRegAddr;
      mem_wreg_q  <= WriteDisable;
      mem_wdata_q <= ZeroWord;
      mem_hi_q    <= ZeroWord;
      mem_lo_q    <= ZeroWord;
      mem_whilo_q <= WriteDisable;
      hilo_temp_q <= bus.hilo_temp_i;
      cnt_q       <= bus.cnt_i;
    end else if (!bus.stall[STALL_EX]) begin
      mem_wd_q    <= bus.ex_wd;
      mem_wreg_q  <= bus.ex_wreg;
      mem_wdata_q <= bus.ex_wdata;
      mem_hi_q    <= bus.ex_hi;
      mem_lo_q    <= bus.ex_lo;
      mem_whilo_q <= bus.ex_whilo;
      hilo_temp_q <= ZeroDWord;
      cnt_q       <= ZeroCnt;
    end
  end

  assign bus.mem_wd      = mem_wd_q;
  assign bus.mem_wreg    = mem_wreg_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_hi      = mem_hi_q;
  assign bus.mem_lo      = mem_lo_q;
  assign bus.mem_whilo   = mem_whilo_q;
  assign bus.hilo_temp_o = hilo_temp_q;
  assign bus.cnt_o       = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Testbench for ex_mem: directed scenarios plus a randomized run checked
// against a per-edge reference of the register's expected contents.
module tb_ex_mem;
  import ex_mem_pkg::*;

  typedef struct packed {
    logic [REG_AW-1:0]   wd;
    logic                wreg;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                whilo;
    logic [2*DATA_W-1:0] ht;
    logic [1:0]          cnt;
  } snap_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  snap_t exp_s;
  snap_t obs_s;

  ex_mem_if bus ();

  ex_mem u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t dut_snap();
    snap_t s;
    s.wd    = bus.mem_wd;
    s.wreg  = bus.mem_wreg;
    s.wdata = bus.mem_wdata;
    s.hi    = bus.mem_hi;
    s.lo    = bus.mem_lo;
    s.whilo = bus.mem_whilo;
    s.ht    = bus.hilo_temp_o;
    s.cnt   = bus.cnt_o;
    return s;
  endfunction

  // Expected register contents after one clock edge, from the stage's rules.
  task automatic model_step();
    logic ex_st, mem_st;
    ex_st  = bus.stall[STALL_EX];
    mem_st = bus.stall[STALL_MEM];
    if (rst == 1'b0 || bus.flush) begin
      exp_s = '0;
    end else if (ex_st && mem_st) begin
      exp_s = exp_s;
    end else if (ex_st) begin
      exp_s     = '0;
      exp_s.ht  = bus.hilo_temp_i;
      exp_s.cnt = bus.cnt_i;
    end else begin
      exp_s.wd    = bus.ex_wd;
      exp_s.wreg  = bus.ex_wreg;
      exp_s.wdata = bus.ex_wdata;
      exp_s.hi    = bus.ex_hi;
      exp_s.lo    = bus.ex_lo;
      exp_s.whilo = bus.ex_whilo;
      exp_s.ht    = '0;
      exp_s.cnt   = 2'b00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_ex(input logic [REG_AW-1:0] wd, input logic wreg,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] hi,
                          input logic [DATA_W-1:0] lo, input logic whilo,
                          input logic [2*DATA_W-1:0] ht, input logic [1:0] cnt);
    bus.ex_wd = wd;  bus.ex_wreg = wreg;  bus.ex_wdata = wdata;
    bus.ex_hi = hi;  bus.ex_lo = lo;      bus.ex_whilo = whilo;
    bus.hilo_temp_i = ht;  bus.cnt_i = cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 6'b000000;
    bus.flush = 1'b0;
    drive_ex(5'd17, 1'b1, 32'hCAFEF00D, 32'h11, 32'h22, 1'b1, 64'h99, 2'd3);
    #2 rst = 1'b0;
    exp_s = '0;
    #1;
    obs_s = dut_snap();
    tests_run++;
    if (obs_s !== snap_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_async got=%h want=0", obs_s);
    end
    tick();
    obs_s = dut_snap();
    tests_run++;
    if (obs_s !== snap_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_held got=%h want=0", obs_s);
    end
    rst = 1'b1;
    $display("[TB] reset done");
  endtask

  task automatic test_load();
    bus.stall = 6'b000000;
    drive_ex(5'd5, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    tick();
    tests_run++;
    if ({bus.mem_wd, bus.mem_wreg, bus.mem_wdata} !== {5'd5, 1'b1, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL load wd=%0d wreg=%b wdata=%h want 5 1 deadbeef",
               bus.mem_wd, bus.mem_wreg, bus.mem_wdata);
    end
    $display("[TB] load wd=%0d wdata=%h", bus.mem_wd, bus.mem_wdata);
  endtask

  task automatic test_bubble();
    bus.stall = 6'b001111;
    drive_ex(5'd9, 1'b1, 32'h12345678, 32'h1, 32'h2, 1'b1, 64'h1234, 2'd1);
    tick();
    tests_run++;
    if ({bus.mem_wreg, bus.mem_wd, bus.mem_whilo, bus.cnt_o, bus.hilo_temp_o}
        !== {1'b0, 5'd0, 1'b0, 2'd1, 64'h1234}) begin
      tests_failed++;
      $display("FAIL bubble wreg=%b wd=%0d whilo=%b cnt=%0d ht=%h want 0 0 0 1 1234",
               bus.mem_wreg, bus.mem_wd, bus.mem_whilo, bus.cnt_o, bus.hilo_temp_o);
    end
    $display("[TB] bubble cnt=%0d ht=%h", bus.cnt_o, bus.hilo_temp_o);
  endtask

  task automatic test_hold();
    bus.stall = 6'b000000;
    drive_ex(5'd7, 1'b1, 32'h00000077, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    tick();
    bus.stall = 6'b011111;
    drive_ex(5'd9, 1'b0, 32'h5555AAAA, 32'h3, 32'h4, 1'b1, 64'hFFFF, 2'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({bus.mem_wd, bus.mem_wdata, bus.cnt_o, bus.hilo_temp_o}
          !== {5'd7, 32'h00000077, 2'd0, 64'h0}) begin
        tests_failed++;
        $display("FAIL hold[%0d] wd=%0d wdata=%h cnt=%0d ht=%h want 7 77 0 0",
                 i, bus.mem_wd, bus.mem_wdata, bus.cnt_o, bus.hilo_temp_o);
      end
      $display("[TB] hold cycle %0d wd=%0d", i, bus.mem_wd);
    end
  endtask

  task automatic test_flush();
    bus.stall = 6'b001111;
    drive_ex(5'd3, 1'b1, 32'hABCD0123, 32'h5, 32'h6, 1'b1, 64'h8888, 2'd2);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    obs_s = dut_snap();
    tests_run++;
    if (obs_s !== snap_t'(0)) begin
      tests_failed++;
      $display("FAIL flush got=%h want=0", obs_s);
    end
    $display("[TB] flush cnt=%0d", bus.cnt_o);
  endtask

  task automatic test_hilo_reset();
    bus.stall = 6'b000000;
    drive_ex(5'd0, 1'b0, 32'h0, 32'hA, 32'hB, 1'b1, 64'h0, 2'd0);
    tick();
    tests_run++;
    if ({bus.mem_whilo, bus.mem_hi, bus.mem_lo} !== {1'b1, 32'hA, 32'hB}) begin
      tests_failed++;
      $display("FAIL hilo whilo=%b hi=%h lo=%h want 1 a b",
               bus.mem_whilo, bus.mem_hi, bus.mem_lo);
    end
    bus.stall = 6'b011111;
    tick();
    tests_run++;
    if ({bus.mem_whilo, bus.mem_hi, bus.mem_lo} !== {1'b1, 32'hA, 32'hB}) begin
      tests_failed++;
      $display("FAIL hilo_hold whilo=%b hi=%h lo=%h want 1 a b",
               bus.mem_whilo, bus.mem_hi, bus.mem_lo);
    end
    #2 rst = 1'b0;
    exp_s = '0;
    #1;
    obs_s = dut_snap();
    tests_run++;
    if (obs_s !== snap_t'(0)) begin
      tests_failed++;
      $display("FAIL hilo_rst got=%h want=0", obs_s);
    end
    @(negedge clk);
    rst = 1'b1;
    // Reset in the middle of a multi-cycle multiply must wipe its progress.
    bus.stall = 6'b001111;
    drive_ex(5'd1, 1'b1, 32'h1, 32'h1, 32'h1, 1'b1, 64'h0123456789ABCDEF, 2'd2);
    tick();
    bus.stall = 6'b011111;
    tick();
    tests_run++;
    if ({bus.cnt_o, bus.hilo_temp_o} !== {2'd2, 64'h0123456789ABCDEF}) begin
      tests_failed++;
      $display("FAIL madd_keep cnt=%0d ht=%h want 2 0123456789abcdef",
               bus.cnt_o, bus.hilo_temp_o);
    end
    #2 rst = 1'b0;
    exp_s = '0;
    #1;
    tests_run++;
    if ({bus.cnt_o, bus.hilo_temp_o} !== {2'd0, 64'h0}) begin
      tests_failed++;
      $display("FAIL madd_rst cnt=%0d ht=%h want 0 0", bus.cnt_o, bus.hilo_temp_o);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] hilo/reset done");
  endtask

  task automatic test_random();
    logic [5:0] pats [3];
    pats[0] = 6'b000000;
    pats[1] = 6'b001111;
    pats[2] = 6'b011111;
    for (int n = 0; n < 300; n++) begin
      bus.stall = pats[$urandom_range(2, 0)];
      bus.flush = ($urandom_range(15, 0) == 0);
      drive_ex(REG_AW'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
               1'($urandom), {$urandom, $urandom}, 2'($urandom));
      tick();
      obs_s = dut_snap();
      tests_run++;
      if (obs_s !== exp_s) begin
        tests_failed++;
        $display("FAIL random[%0d] got=%h want=%h", n, obs_s, exp_s);
      end
      $display("[TB] txn %0d stall=%b flush=%b wd=%0d cnt=%0d",
               n, bus.stall, bus.flush, obs_s.wd, obs_s.cnt);
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_s        = '0;
    test_reset();
    test_load();
    test_bubble();
    test_hold();
    test_flush();
    test_hilo_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
